// File: rtl/galaksija_tape_rec_if.sv
// Tape buffer write port from the cassette recorder to the host-visible buffer.
// Master drives a 1-cycle write strobe with address and data; there is no backpressure.
interface galaksija_tape_rec_if #(
  parameter int ADDR_W = 14
) ();
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;

  modport master (output buf_we, output buf_addr, output buf_data);
  modport slave  (input  buf_we, input  buf_addr, input  buf_data);
endinterface

// File: rtl/galaksija_tape_rec.sv
// Cassette recorder: decodes the CPU tape-out pulse train into bytes and writes them to the tape buffer.
// Latency: byte strobe 1 cycle after its 8th bit commits. No backpressure; the buffer accepts every write.
// Optional running byte checksum on rec_sum: define GALAKSIJA_TAPE_REC_SUM_EN.
module galaksija_tape_rec #(
  parameter int          ADDR_W   = 14,
  parameter logic [7:0]  OUT_MASK = 8'h44,
  parameter logic [15:0] HALF_MIN = 16'd600,
  parameter logic [15:0] CELL_MIN = 16'd3000,
  parameter logic [23:0] TIMEOUT  = 24'd2000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rec_en,
  input  logic                latch_wr,
  input  logic [7:0]          latch_data,
  galaksija_tape_rec_if.master buf_if,
  output logic [ADDR_W:0]     rec_len,
  output logic                rec_busy,
  output logic                rec_done,
  output logic                rec_ovf,
  output logic [7:0]          rec_sum
);
  typedef enum logic [1:0] {IDLE, ARMED, CELL, DONE} state_t;

  localparam logic [ADDR_W:0] LEN_ONE = 1;

  state_t      state;
  logic        level, level_q, rec_en_q, one_flag;
  logic [2:0]  bitcnt;
  logic [7:0]  shreg;
  logic [23:0] cnt;

  logic       pulse, full_wr, arm, cell_pulse, commit_byte;
  logic [7:0] new_byte;

  always_comb begin
    pulse       = level & ~level_q;
    full_wr     = buf_if.buf_we & (&buf_if.buf_addr);
    arm         = (state == IDLE) & rec_en & ~rec_en_q;
    cell_pulse  = (state == CELL) & rec_en & ~full_wr & pulse & (cnt >= 24'(CELL_MIN));
    commit_byte = cell_pulse & (bitcnt == 3'd7);
    new_byte    = {one_flag, shreg[7:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      level           <= 1'b0;
      level_q         <= 1'b0;
      rec_en_q        <= 1'b0;
      one_flag        <= 1'b0;
      bitcnt          <= 3'd0;
      shreg           <= 8'h00;
      cnt             <= 24'd0;
      buf_if.buf_we   <= 1'b0;
      buf_if.buf_addr <= '0;
      buf_if.buf_data <= 8'h00;
      rec_len         <= '0;
      rec_busy        <= 1'b0;
      rec_done        <= 1'b0;
      rec_ovf         <= 1'b0;
    end else begin
      rec_en_q      <= rec_en;
      level_q       <= level;
      buf_if.buf_we <= 1'b0;
      if (latch_wr) level <= |(latch_data & OUT_MASK);
      if (cnt != '1) cnt <= cnt + 24'd1;

      case (state)
        IDLE: if (arm) begin
          state           <= ARMED;
          rec_busy        <= 1'b1;
          rec_len         <= '0;
          buf_if.buf_addr <= '0;
          rec_ovf         <= 1'b0;
          rec_done        <= 1'b0;
        end
        ARMED: if (!rec_en) begin
          state    <= IDLE;
          rec_busy <= 1'b0;
        end else if (pulse) begin
          state    <= CELL;
          cnt      <= 24'd0;
          one_flag <= 1'b0;
          bitcnt   <= 3'd0;
          shreg    <= 8'h00;
        end
        CELL: if (!rec_en) begin
          state    <= IDLE;
          rec_busy <= 1'b0;
          shreg    <= 8'h00;
          bitcnt   <= 3'd0;
          one_flag <= 1'b0;
        end else if (full_wr) begin
          state    <= DONE;
          rec_busy <= 1'b0;
          rec_done <= 1'b1;
          rec_ovf  <= 1'b1;
        end else if (pulse) begin
          // Mid-cell pulses keep cnt running: cell length is measured from the cell start.
          if (cell_pulse) begin
            shreg    <= new_byte;
            bitcnt   <= bitcnt + 3'd1;
            cnt      <= 24'd0;
            one_flag <= 1'b0;
            if (commit_byte) begin
              buf_if.buf_we   <= 1'b1;
              buf_if.buf_data <= new_byte;
              buf_if.buf_addr <= rec_len[ADDR_W-1:0];
              rec_len         <= rec_len + LEN_ONE;
            end
          end else if (cnt >= 24'(HALF_MIN)) begin
            one_flag <= 1'b1;
          end
        end else if (cnt == TIMEOUT - 24'd1) begin
          state    <= DONE;
          rec_busy <= 1'b0;
          rec_done <= 1'b1;
        end
        DONE: if (!rec_en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GALAKSIJA_TAPE_REC_SUM_EN
  always_ff @(posedge clk) begin
    if (reset || arm) rec_sum <= 8'h00;
    else if (commit_byte) rec_sum <= rec_sum + new_byte;
  end
`else
  assign rec_sum = 8'h00;
`endif
endmodule

// File: tb/tb_galaksija_tape_rec.sv
// Bench for galaksija_tape_rec: directed recordings plus randomized pulse timing, checked against a byte-level model.
module tb_galaksija_tape_rec;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, rec_en, latch_wr;
  logic [7:0]    latch_data;
  logic [AW:0]   rec_len;
  logic          rec_busy, rec_done, rec_ovf;
  logic [7:0]    rec_sum;

  galaksija_tape_rec_if #(.ADDR_W(AW)) bus ();

  galaksija_tape_rec #(
    .ADDR_W(AW), .OUT_MASK(8'h44), .HALF_MIN(16'd4), .CELL_MIN(16'd20), .TIMEOUT(24'd100)
  ) dut (
    .clk(clk), .reset(reset), .rec_en(rec_en), .latch_wr(latch_wr), .latch_data(latch_data),
    .buf_if(bus), .rec_len(rec_len), .rec_busy(rec_busy), .rec_done(rec_done),
    .rec_ovf(rec_ovf), .rec_sum(rec_sum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_pulse = 0;

  logic [7:0]    wq_data[$];
  logic [AW-1:0] wq_addr[$];
  logic [7:0]    exp_q[$];

  always @(negedge clk) if (bus.buf_we === 1'b1) begin
    wq_data.push_back(bus.buf_data);
    wq_addr.push_back(bus.buf_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] hi_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if ((b & 8'h44) == 8'h00) b = b | 8'h40;
    return b;
  endfunction

  function automatic logic [7:0] lo_byte();
    return 8'($urandom) & 8'hBB;
  endfunction

  // Pulse becomes visible to the recorder in cycle t: level rises at t, falls at t+1.
  task automatic pulse_at(input int t);
    while (cyc < t - 1) tick();
    latch_wr = 1'b1;
    latch_data = hi_byte();
    tick();
    last_pulse = cyc;
    latch_data = lo_byte();
    tick();
    latch_wr = 1'b0;
  endtask

  // One cell per bit, LSB first; a '1' gets a mid-cell pulse, optional glitch right after the cell start.
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit rnd, input bit glitch);
    int start, len, mid, g;
    for (int i = 0; i < nbits; i++) begin
      start = last_pulse;
      len = rnd ? int'($urandom_range(22, 30)) : 24;
      mid = rnd ? int'($urandom_range(7, 14)) : 12;
      g   = rnd ? int'($urandom_range(2, 4)) : 2;
      if (glitch && (!rnd || $urandom_range(0, 1) == 1)) pulse_at(start + g);
      if (b[i]) pulse_at(start + mid);
      pulse_at(start + len);
    end
  endtask

  function automatic logic [7:0] exp_sum(input int n);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < n; i++) s = s + exp_q[i];
`ifdef GALAKSIJA_TAPE_REC_SUM_EN
    return s;
`else
    return 8'h00;
`endif
  endfunction

  initial begin
    logic [7:0] b;
    int lp;
    reset = 1'b1; rec_en = 1'b0; latch_wr = 1'b0; latch_data = 8'h00;
    repeat (3) tick();
    check("rst_we",   32'(bus.buf_we), 0);
    check("rst_addr", 32'(bus.buf_addr), 0);
    check("rst_data", 32'(bus.buf_data), 0);
    check("rst_len",  32'(rec_len), 0);
    check("rst_busy", 32'(rec_busy), 0);
    check("rst_done", 32'(rec_done), 0);
    check("rst_ovf",  32'(rec_ovf), 0);
    check("rst_sum",  32'(rec_sum), 0);
    reset = 1'b0;
    tick();

    // Single 0x00 byte at fixed 24-cycle cells, then timeout
    rec_en = 1'b1;
    tick();
    check("t1_busy", 32'(rec_busy), 1);
    pulse_at(cyc + 2);
    send_bits(8'h00, 8, 1'b0, 1'b0);
    check("t1_we",   32'(bus.buf_we), 1);
    check("t1_data", 32'(bus.buf_data), 32'h00);
    check("t1_addr", 32'(bus.buf_addr), 0);
    check("t1_len",  32'(rec_len), 1);
    tick();
    check("t1_we_pulse", 32'(bus.buf_we), 0);
    repeat (110) tick();
    check("t1_done", 32'(rec_done), 1);
    check("t1_idle_busy", 32'(rec_busy), 0);
    rec_en = 1'b0;
    repeat (2) tick();
    check("t1_len_kept",  32'(rec_len), 1);
    check("t1_done_kept", 32'(rec_done), 1);

    // 0xA5 with mid pulses and early glitches, then a truncated byte timing out
    wq_data.delete(); wq_addr.delete(); exp_q.delete();
    rec_en = 1'b1;
    tick();
    check("t2_len_clr",  32'(rec_len), 0);
    check("t2_done_clr", 32'(rec_done), 0);
    check("t2_sum_clr",  32'(rec_sum), 0);
    pulse_at(cyc + 2);
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8, 1'b0, 1'b1);
    repeat (3) tick();
    check("t2_nwr", 32'(wq_data.size()), 1);
    check("t2_data", 32'(wq_data[0]), 32'hA5);
    check("t2_sum", 32'(rec_sum), 32'(exp_sum(1)));
    send_bits(8'hFF, 3, 1'b0, 1'b0);
    lp = last_pulse;
    while (cyc < lp + 100) tick();
    check("t4_not_yet", 32'(rec_done), 0);
    tick();
    check("t4_done", 32'(rec_done), 1);
    check("t4_busy", 32'(rec_busy), 0);
    check("t4_len",  32'(rec_len), 1);
    check("t4_nwr",  32'(wq_data.size()), 1);

    // 17 random bytes at random timing overflow the 16-byte buffer
    rec_en = 1'b0;
    repeat (2) tick();
    wq_data.delete(); wq_addr.delete(); exp_q.delete();
    rec_en = 1'b1;
    tick();
    pulse_at(cyc + 2);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_bits(b, 8, 1'b1, 1'b1);
    end
    repeat (5) tick();
    check("t5_nwr", 32'(wq_data.size()), 16);
    for (int i = 0; i < 16 && i < wq_data.size(); i++) begin
      check($sformatf("t5_data%0d", i), 32'(wq_data[i]), 32'(exp_q[i]));
      check($sformatf("t5_addr%0d", i), 32'(wq_addr[i]), i);
    end
    check("t5_ovf",  32'(rec_ovf), 1);
    check("t5_done", 32'(rec_done), 1);
    check("t5_len",  32'(rec_len), 16);
    check("t5_busy", 32'(rec_busy), 0);
    check("t5_sum",  32'(rec_sum), 32'(exp_sum(16)));

    // Abort mid-byte, then re-arm and record one clean byte
    rec_en = 1'b0;
    repeat (2) tick();
    wq_data.delete(); wq_addr.delete(); exp_q.delete();
    rec_en = 1'b1;
    tick();
    pulse_at(cyc + 2);
    send_bits(8'hFF, 5, 1'b1, 1'b0);
    pulse_at(last_pulse + 10);
    rec_en = 1'b0;
    tick();
    check("t6_abort_busy", 32'(rec_busy), 0);
    repeat (30) tick();
    check("t6_nwr",  32'(wq_data.size()), 0);
    check("t6_done", 32'(rec_done), 0);
    rec_en = 1'b1;
    tick();
    check("t6_len_clr", 32'(rec_len), 0);
    check("t6_busy",    32'(rec_busy), 1);
    pulse_at(cyc + 2);
    b = 8'($urandom);
    exp_q.push_back(b);
    send_bits(b, 8, 1'b1, 1'b1);
    repeat (3) tick();
    check("t6_nwr2", 32'(wq_data.size()), 1);
    if (wq_data.size() > 0) check("t6_data", 32'(wq_data[0]), 32'(b));
    check("t6_len", 32'(rec_len), 1);
    check("t6_sum", 32'(rec_sum), 32'(exp_sum(1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
